// File: rtl/dma_slave_arbiter.sv
// Two-to-one AXI4-Lite arbiter in front of the DMA register slave.
// Write and read paths each run their own round-robin FSM with one outstanding transaction.
module dma_slave_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // port 0 (CPU)
    input  logic [ADDR_WIDTH-1:0]     S0_AWADDR,
    input  logic                      S0_AWVALID,
    output logic                      S0_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S0_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S0_WSTRB,
    input  logic                      S0_WVALID,
    output logic                      S0_WREADY,
    output logic [1:0]                S0_BRESP,
    output logic                      S0_BVALID,
    input  logic                      S0_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S0_ARADDR,
    input  logic                      S0_ARVALID,
    output logic                      S0_ARREADY,
    output logic [DATA_WIDTH-1:0]     S0_RDATA,
    output logic [1:0]                S0_RRESP,
    output logic                      S0_RVALID,
    input  logic                      S0_RREADY,
    // port 1 (debug/test)
    input  logic [ADDR_WIDTH-1:0]     S1_AWADDR,
    input  logic                      S1_AWVALID,
    output logic                      S1_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S1_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S1_WSTRB,
    input  logic                      S1_WVALID,
    output logic                      S1_WREADY,
    output logic [1:0]                S1_BRESP,
    output logic                      S1_BVALID,
    input  logic                      S1_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S1_ARADDR,
    input  logic                      S1_ARVALID,
    output logic                      S1_ARREADY,
    output logic [DATA_WIDTH-1:0]     S1_RDATA,
    output logic [1:0]                S1_RRESP,
    output logic                      S1_RVALID,
    input  logic                      S1_RREADY,
    // downstream DMA slave
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_XFER = 2'd1, R_RESP = 2'd2} r_state_t;

    w_state_t r_wstate;
    logic     r_wgnt;
    logic     r_wlast;
    logic     r_aw_done;
    logic     r_w_done;

    r_state_t r_rstate;
    logic     r_rgnt;
    logic     r_rlast;

    logic                  w_wxfer;
    logic                  w_wresp;
    logic                  w_rxfer;
    logic                  w_rresp;
    logic                  w_wwin;
    logic                  w_rwin;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_awready_up;
    logic                  w_wready_up;
    logic                  w_arready_up;
    logic                  w_bvalid_up;
    logic                  w_rvalid_up;
    logic [1:0]            w_bresp_up;
    logic [1:0]            w_rresp_up;
    logic [DATA_WIDTH-1:0] w_rdata_up;

    assign w_wxfer = (r_wstate == W_XFER);
    assign w_wresp = (r_wstate == W_RESP);
    assign w_rxfer = (r_rstate == R_XFER);
    assign w_rresp = (r_rstate == R_RESP);

    // On a tie the port that was not served last wins.
    assign w_wwin = (S0_AWVALID & S1_AWVALID) ? ~r_wlast : S1_AWVALID;
    assign w_rwin = (S0_ARVALID & S1_ARVALID) ? ~r_rlast : S1_ARVALID;

    // Purpose: route the granted port's write request onto the downstream channel.
    always_comb begin
        M_AWADDR  = {ADDR_WIDTH{1'b0}};
        M_AWVALID = 1'b0;
        M_WDATA   = {DATA_WIDTH{1'b0}};
        M_WSTRB   = {STRB_WIDTH{1'b0}};
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        if (w_wxfer) begin
            M_AWADDR  = r_wgnt ? S1_AWADDR : S0_AWADDR;
            M_AWVALID = (r_wgnt ? S1_AWVALID : S0_AWVALID) & ~r_aw_done;
            M_WDATA   = r_wgnt ? S1_WDATA : S0_WDATA;
            M_WSTRB   = r_wgnt ? S1_WSTRB : S0_WSTRB;
            M_WVALID  = (r_wgnt ? S1_WVALID : S0_WVALID) & ~r_w_done;
        end else if (w_wresp) begin
            M_BREADY  = r_wgnt ? S1_BREADY : S0_BREADY;
        end else begin
            M_BREADY  = 1'b0;
        end
    end

    assign w_aw_hs      = M_AWVALID & M_AWREADY;
    assign w_w_hs       = M_WVALID & M_WREADY;
    assign w_awready_up = w_wxfer & ~r_aw_done & M_AWREADY;
    assign w_wready_up  = w_wxfer & ~r_w_done & M_WREADY;
    assign w_bvalid_up  = w_wresp & M_BVALID;
    assign w_bresp_up   = w_wresp ? M_BRESP : 2'b00;

    assign S0_AWREADY = w_awready_up & ~r_wgnt;
    assign S1_AWREADY = w_awready_up &  r_wgnt;
    assign S0_WREADY  = w_wready_up  & ~r_wgnt;
    assign S1_WREADY  = w_wready_up  &  r_wgnt;
    assign S0_BVALID  = w_bvalid_up  & ~r_wgnt;
    assign S1_BVALID  = w_bvalid_up  &  r_wgnt;
    assign S0_BRESP   = r_wgnt ? 2'b00 : w_bresp_up;
    assign S1_BRESP   = r_wgnt ? w_bresp_up : 2'b00;

    // Purpose: write-path arbitration FSM with AW/W completion tracking.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_wgnt    <= 1'b0;
            r_wlast   <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (S0_AWVALID | S1_AWVALID) begin
                        r_wgnt   <= w_wwin;
                        r_wstate <= W_XFER;
                    end
                end
                W_XFER: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (M_BVALID & M_BREADY) begin
                        r_wlast   <= r_wgnt;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Purpose: route the granted port's read request onto the downstream channel.
    always_comb begin
        M_ARADDR  = {ADDR_WIDTH{1'b0}};
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        if (w_rxfer) begin
            M_ARADDR  = r_rgnt ? S1_ARADDR : S0_ARADDR;
            M_ARVALID = r_rgnt ? S1_ARVALID : S0_ARVALID;
        end else if (w_rresp) begin
            M_RREADY  = r_rgnt ? S1_RREADY : S0_RREADY;
        end else begin
            M_RREADY  = 1'b0;
        end
    end

    assign w_arready_up = w_rxfer & M_ARREADY;
    assign w_rvalid_up  = w_rresp & M_RVALID;
    assign w_rresp_up   = w_rresp ? M_RRESP : 2'b00;
    assign w_rdata_up   = w_rresp ? M_RDATA : {DATA_WIDTH{1'b0}};

    assign S0_ARREADY = w_arready_up & ~r_rgnt;
    assign S1_ARREADY = w_arready_up &  r_rgnt;
    assign S0_RVALID  = w_rvalid_up  & ~r_rgnt;
    assign S1_RVALID  = w_rvalid_up  &  r_rgnt;
    assign S0_RRESP   = r_rgnt ? 2'b00 : w_rresp_up;
    assign S1_RRESP   = r_rgnt ? w_rresp_up : 2'b00;
    assign S0_RDATA   = r_rgnt ? {DATA_WIDTH{1'b0}} : w_rdata_up;
    assign S1_RDATA   = r_rgnt ? w_rdata_up : {DATA_WIDTH{1'b0}};

    // Purpose: read-path arbitration FSM.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rgnt   <= 1'b0;
            r_rlast  <= 1'b1;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S0_ARVALID | S1_ARVALID) begin
                        r_rgnt   <= w_rwin;
                        r_rstate <= R_XFER;
                    end
                end
                R_XFER: begin
                    if (M_ARVALID & M_ARREADY) r_rstate <= R_RESP;
                end
                R_RESP: begin
                    if (M_RVALID & M_RREADY) begin
                        r_rlast  <= r_rgnt;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_slave_arbiter.sv
// Directed bench for dma_slave_arbiter; the bench drives the downstream slave handshakes itself.
module tb_dma_slave_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S0_AWADDR, S1_AWADDR, S0_ARADDR, S1_ARADDR;
    logic        S0_AWVALID, S1_AWVALID, S0_AWREADY, S1_AWREADY;
    logic [31:0] S0_WDATA, S1_WDATA;
    logic [3:0]  S0_WSTRB, S1_WSTRB;
    logic        S0_WVALID, S1_WVALID, S0_WREADY, S1_WREADY;
    logic [1:0]  S0_BRESP, S1_BRESP;
    logic        S0_BVALID, S1_BVALID, S0_BREADY, S1_BREADY;
    logic        S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
    logic [31:0] S0_RDATA, S1_RDATA;
    logic [1:0]  S0_RRESP, S1_RRESP;
    logic        S0_RVALID, S1_RVALID, S0_RREADY, S1_RREADY;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [3:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    dma_slave_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S0_AWADDR(S0_AWADDR), .S0_AWVALID(S0_AWVALID), .S0_AWREADY(S0_AWREADY),
        .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
        .S0_BRESP(S0_BRESP), .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
        .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_AWADDR(S1_AWADDR), .S1_AWVALID(S1_AWVALID), .S1_AWREADY(S1_AWREADY),
        .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
        .S1_BRESP(S1_BRESP), .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        S0_AWADDR = 32'h0; S0_AWVALID = 1'b0; S0_WDATA = 32'h0; S0_WSTRB = 4'h0; S0_WVALID = 1'b0;
        S0_BREADY = 1'b0; S0_ARADDR = 32'h0; S0_ARVALID = 1'b0; S0_RREADY = 1'b0;
        S1_AWADDR = 32'h0; S1_AWVALID = 1'b0; S1_WDATA = 32'h0; S1_WSTRB = 4'h0; S1_WVALID = 1'b0;
        S1_BREADY = 1'b0; S1_ARADDR = 32'h0; S1_ARVALID = 1'b0; S1_RREADY = 1'b0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BRESP = 2'b00; M_BVALID = 1'b0;
        M_ARREADY = 1'b0; M_RDATA = 32'h0; M_RRESP = 2'b00; M_RVALID = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        step();
        step();
        ARESET = 1'b0;
    endtask

    logic exp_g [3];

    initial begin
        ARESET = 1'b1;
        clear_inputs();
        step();
        // reset: outputs stay 0 even with requests and readies present
        S0_AWVALID = 1'b1; S0_ARVALID = 1'b1; M_AWREADY = 1'b1; M_ARREADY = 1'b1; M_BVALID = 1'b1;
        #1;
        chk("rst_m_awvalid", {31'h0, M_AWVALID}, 32'h0);
        chk("rst_m_arvalid", {31'h0, M_ARVALID}, 32'h0);
        chk("rst_s0_awready", {31'h0, S0_AWREADY}, 32'h0);
        chk("rst_s0_bvalid", {31'h0, S0_BVALID}, 32'h0);
        clear_inputs();
        step();
        ARESET = 1'b0;

        // T1: single write port 0
        S0_AWADDR = 32'h10; S0_AWVALID = 1'b1; S0_WDATA = 32'hDEADBEEF; S0_WSTRB = 4'hF;
        S0_WVALID = 1'b1; S0_BREADY = 1'b1; M_AWREADY = 1'b1; M_WREADY = 1'b1;
        #1;
        chk("t1_c0_awvalid", {31'h0, M_AWVALID}, 32'h0);
        step();
        chk("t1_awvalid", {31'h0, M_AWVALID}, 32'h1);
        chk("t1_awaddr", M_AWADDR, 32'h10);
        chk("t1_wvalid", {31'h0, M_WVALID}, 32'h1);
        chk("t1_wdata", M_WDATA, 32'hDEADBEEF);
        chk("t1_wstrb", {28'h0, M_WSTRB}, 32'hF);
        chk("t1_s0_awready", {31'h0, S0_AWREADY}, 32'h1);
        chk("t1_s1_awready", {31'h0, S1_AWREADY}, 32'h0);
        chk("t1_s1_wready", {31'h0, S1_WREADY}, 32'h0);
        step();
        S0_AWVALID = 1'b0; S0_WVALID = 1'b0; M_BVALID = 1'b1; M_BRESP = 2'b00;
        #1;
        chk("t1_s0_bvalid", {31'h0, S0_BVALID}, 32'h1);
        chk("t1_s0_bresp", {30'h0, S0_BRESP}, 32'h0);
        chk("t1_m_bready", {31'h0, M_BREADY}, 32'h1);
        chk("t1_resp_awvalid", {31'h0, M_AWVALID}, 32'h0);
        chk("t1_s1_bvalid", {31'h0, S1_BVALID}, 32'h0);
        step();
        chk("t1_idle_bvalid", {31'h0, S0_BVALID}, 32'h0);
        clear_inputs();

        // T2: ties after reset rotate 0,1,0
        do_reset();
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            S0_AWADDR = 32'h100; S0_WDATA = 32'h0A0A0A0A; S0_WSTRB = 4'hF;
            S1_AWADDR = 32'h200; S1_WDATA = 32'h0B0B0B0B; S1_WSTRB = 4'hF;
            S0_AWVALID = 1'b1; S0_WVALID = 1'b1; S1_AWVALID = 1'b1; S1_WVALID = 1'b1;
            S0_BREADY = 1'b1; S1_BREADY = 1'b1; M_AWREADY = 1'b1; M_WREADY = 1'b1;
            step();
            chk("t2_awaddr", M_AWADDR, exp_g[r] ? 32'h200 : 32'h100);
            chk("t2_s0_awready", {31'h0, S0_AWREADY}, {31'h0, ~exp_g[r]});
            chk("t2_s1_awready", {31'h0, S1_AWREADY}, {31'h0, exp_g[r]});
            step();
            if (exp_g[r]) begin
                S1_AWVALID = 1'b0; S1_WVALID = 1'b0;
            end else begin
                S0_AWVALID = 1'b0; S0_WVALID = 1'b0;
            end
            M_BVALID = 1'b1;
            #1;
            chk("t2_s0_bvalid", {31'h0, S0_BVALID}, {31'h0, ~exp_g[r]});
            chk("t2_s1_bvalid", {31'h0, S1_BVALID}, {31'h0, exp_g[r]});
            step();
            M_BVALID = 1'b0;
        end
        clear_inputs();

        // T3: port 1 W early, AWREADY delayed
        S1_WDATA = 32'hCAFEF00D; S1_WSTRB = 4'h3; S1_WVALID = 1'b1; S1_BREADY = 1'b1;
        M_WREADY = 1'b1;
        #1;
        chk("t3_early_wvalid0", {31'h0, M_WVALID}, 32'h0);
        chk("t3_early_wready0", {31'h0, S1_WREADY}, 32'h0);
        step();
        chk("t3_early_wvalid1", {31'h0, M_WVALID}, 32'h0);
        step();
        S1_AWADDR = 32'h20; S1_AWVALID = 1'b1;
        #1;
        chk("t3_early_wvalid2", {31'h0, M_WVALID}, 32'h0);
        step();
        chk("t3_x1_awvalid", {31'h0, M_AWVALID}, 32'h1);
        chk("t3_x1_wvalid", {31'h0, M_WVALID}, 32'h1);
        chk("t3_x1_wdata", M_WDATA, 32'hCAFEF00D);
        chk("t3_x1_s1_wready", {31'h0, S1_WREADY}, 32'h1);
        chk("t3_x1_s1_awready", {31'h0, S1_AWREADY}, 32'h0);
        step();
        S1_WVALID = 1'b0;
        #1;
        chk("t3_x2_wvalid", {31'h0, M_WVALID}, 32'h0);
        chk("t3_x2_awvalid", {31'h0, M_AWVALID}, 32'h1);
        chk("t3_x2_bready", {31'h0, M_BREADY}, 32'h0);
        step();
        chk("t3_x3_bready", {31'h0, M_BREADY}, 32'h0);
        step();
        M_AWREADY = 1'b1;
        #1;
        chk("t3_x4_s1_awready", {31'h0, S1_AWREADY}, 32'h1);
        chk("t3_x4_bready", {31'h0, M_BREADY}, 32'h0);
        step();
        S1_AWVALID = 1'b0; M_AWREADY = 1'b0; M_BVALID = 1'b1;
        #1;
        chk("t3_resp_bready", {31'h0, M_BREADY}, 32'h1);
        chk("t3_resp_awvalid", {31'h0, M_AWVALID}, 32'h0);
        chk("t3_resp_wvalid", {31'h0, M_WVALID}, 32'h0);
        chk("t3_resp_s1_bvalid", {31'h0, S1_BVALID}, 32'h1);
        step();
        M_BVALID = 1'b0;
        #1;
        chk("t3_idle_bready", {31'h0, M_BREADY}, 32'h0);
        clear_inputs();

        // T4: concurrent write port 0 and read port 1
        S0_AWADDR = 32'h04; S0_AWVALID = 1'b1; S0_WDATA = 32'hA5A5A5A5; S0_WSTRB = 4'hF;
        S0_WVALID = 1'b1; S0_BREADY = 1'b1; S1_ARADDR = 32'h08; S1_ARVALID = 1'b1; S1_RREADY = 1'b1;
        M_AWREADY = 1'b1; M_WREADY = 1'b1; M_ARREADY = 1'b1;
        step();
        chk("t4_awaddr", M_AWADDR, 32'h04);
        chk("t4_araddr", M_ARADDR, 32'h08);
        chk("t4_s1_arready", {31'h0, S1_ARREADY}, 32'h1);
        chk("t4_s0_arready", {31'h0, S0_ARREADY}, 32'h0);
        chk("t4_s0_awready", {31'h0, S0_AWREADY}, 32'h1);
        step();
        S0_AWVALID = 1'b0; S0_WVALID = 1'b0; S1_ARVALID = 1'b0;
        M_BVALID = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'h12345678; M_RRESP = 2'b00;
        #1;
        chk("t4_s1_rdata", S1_RDATA, 32'h12345678);
        chk("t4_s1_rvalid", {31'h0, S1_RVALID}, 32'h1);
        chk("t4_s0_rvalid", {31'h0, S0_RVALID}, 32'h0);
        chk("t4_s0_rdata", S0_RDATA, 32'h0);
        chk("t4_s0_bvalid", {31'h0, S0_BVALID}, 32'h1);
        chk("t4_s1_bvalid", {31'h0, S1_BVALID}, 32'h0);
        chk("t4_m_rready", {31'h0, M_RREADY}, 32'h1);
        step();
        clear_inputs();

        // T5: BRESP=2 held while BREADY low
        S0_AWADDR = 32'h0C; S0_AWVALID = 1'b1; S0_WDATA = 32'h5; S0_WSTRB = 4'h1; S0_WVALID = 1'b1;
        M_AWREADY = 1'b1; M_WREADY = 1'b1;
        step();
        step();
        S0_AWVALID = 1'b0; S0_WVALID = 1'b0; M_BVALID = 1'b1; M_BRESP = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_hold_bvalid", {31'h0, S0_BVALID}, 32'h1);
            chk("t5_hold_bresp", {30'h0, S0_BRESP}, 32'h2);
            chk("t5_hold_bready", {31'h0, M_BREADY}, 32'h0);
            step();
        end
        S0_BREADY = 1'b1;
        #1;
        chk("t5_bready", {31'h0, M_BREADY}, 32'h1);
        step();
        chk("t5_idle_bvalid", {31'h0, S0_BVALID}, 32'h0);
        chk("t5_idle_bready", {31'h0, M_BREADY}, 32'h0);
        clear_inputs();

        // T6: full port-0 read, then reset in R_RESP, then tie goes to port 0
        S0_ARADDR = 32'h2C; S0_ARVALID = 1'b1; S0_RREADY = 1'b1; M_ARREADY = 1'b1;
        step();
        step();
        S0_ARVALID = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'h11;
        #1;
        chk("t6_rdata", S0_RDATA, 32'h11);
        step();
        M_RVALID = 1'b0;
        S0_ARADDR = 32'h30; S0_ARVALID = 1'b1; S0_RREADY = 1'b0;
        step();
        step();
        S0_ARVALID = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'hFFFF0000;
        #1;
        chk("t6_resp_rvalid", {31'h0, S0_RVALID}, 32'h1);
        S0_RREADY = 1'b1;
        ARESET = 1'b1;
        #1;
        chk("t6_rst_rvalid", {31'h0, S0_RVALID}, 32'h0);
        chk("t6_rst_rdata", S0_RDATA, 32'h0);
        chk("t6_rst_rready", {31'h0, M_RREADY}, 32'h0);
        clear_inputs();
        step();
        ARESET = 1'b0;
        S0_ARADDR = 32'h40; S0_ARVALID = 1'b1; S1_ARADDR = 32'h50; S1_ARVALID = 1'b1;
        M_ARREADY = 1'b1;
        step();
        chk("t6_tie_araddr", M_ARADDR, 32'h40);
        chk("t6_tie_s0_arready", {31'h0, S0_ARREADY}, 32'h1);
        chk("t6_tie_s1_arready", {31'h0, S1_ARREADY}, 32'h0);
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_slave_arbiter.md
# dma_slave_arbiter

Two-to-one AXI4-Lite arbiter that shares the DMA controller's single register slave port between two masters: port 0 is the CPU and port 1 is the debug/test master. Write and read paths are arbitrated independently, each with round-robin priority and one outstanding transaction per path. The block sits between the interconnect and the DMA slave, so the slave sees a single well-formed AXI4-Lite master.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports; WSTRB width is DATA_WIDTH/8

Ports, with i ∈ {0,1}:
- ACLK  in  1  clock; all logic is on the rising edge
- ARESET  in  1  reset, asynchronous, active-high
- S{i}_AWADDR/AWVALID  in  ADDR_WIDTH/1  upstream write address; S{i}_AWREADY  out  1
- S{i}_WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1  upstream write data; S{i}_WREADY  out  1
- S{i}_BRESP/BVALID  out  2/1  upstream write response; S{i}_BREADY  in  1
- S{i}_ARADDR/ARVALID  in  ADDR_WIDTH/1  upstream read address; S{i}_ARREADY  out  1
- S{i}_RDATA/RRESP/RVALID  out  DATA_WIDTH/2/1  upstream read data; S{i}_RREADY  in  1
- M_AWADDR/AWVALID  out, M_AWREADY  in  downstream write address to the DMA slave
- M_WDATA/WSTRB/WVALID  out, M_WREADY  in  downstream write data
- M_BRESP/BVALID  in, M_BREADY  out  downstream write response
- M_ARADDR/ARVALID  out, M_ARREADY  in  downstream read address
- M_RDATA/RRESP/RVALID  in, M_RREADY  out  downstream read data

## Operation
- Write FSM states: W_IDLE, W_XFER, W_RESP.
- W_IDLE:
  - Request from port i is S{i}_AWVALID. WVALID alone is not a request.
  - If any request is present, register wgnt and go to W_XFER.
  - If both ports request, the port other than wlast wins.
- W_XFER:
  - AW and W of port wgnt are combinationally muxed to M_AW* and M_W*. M_AWREADY and M_WREADY are routed back to that port only.
  - aw_done and w_done flags record each handshake. AW and W may complete in either order or in the same cycle.
  - After an AW handshake, M_AWVALID is held 0 (same for W after a W handshake).
  - When both flags are set, go to W_RESP.
- W_RESP:
  - M_BRESP and M_BVALID are routed to port wgnt; S{wgnt}_BREADY is routed to M_BREADY.
  - On the B handshake: wlast ← wgnt, clear the flags, go to W_IDLE.
- Read FSM states: R_IDLE, R_XFER, R_RESP.
  - Same scheme as the write FSM, using ARVALID as the request, with rgnt and rlast.
  - R_XFER ends on the AR handshake; R_RESP ends on the R handshake.
- The write and read FSMs are fully independent. A write from port 0 and a read from port 1 may be in flight simultaneously.
- Non-granted ports see all READY and VALID outputs at 0 and all data/resp outputs at 0.
- When no grant is active, all M_* outputs are 0.
- Responses (BRESP, RRESP, RDATA) pass through unmodified. The arbiter never generates an error response itself.

## Timing
- Reset (asynchronous assert) drives:
  - both FSMs to IDLE
  - wlast = rlast = 1, so port 0 wins the first tie
  - aw_done = w_done = 0
  - every S{i}_* and M_* output to 0
- Arbitration latency: a request visible in cycle 0 (FSM in IDLE) produces M_AWVALID/M_ARVALID = 1 in cycle 1.
- Zero added latency inside XFER/RESP: all ready, valid and data paths are combinational muxes selected by the registered grant.
- Minimum path occupancy: write = 3 cycles (IDLE, XFER with AW and W together, RESP with BVALID immediate). Read = 3 cycles.
- Back-to-back requests from one port: the FSM passes through one IDLE cycle between transactions.
- Masters must hold VALID and payload stable until their handshake (AXI rule). A request that drops before grant is simply not served.
- Reset asserted mid-transaction aborts it immediately: all outputs go to 0 with no B or R returned. The downstream slave is reset on the same ARESET.

## Test plan
- Single write, port 0, addr 0x10, data 0xDEADBEEF, WSTRB 0xF, slave ready immediately: M_AW/M_W show 0x10/0xDEADBEEF in cycle 1. S0_BVALID with BRESP 0 follows. S1 outputs stay 0 throughout.
- Simultaneous AWVALID on both ports after reset, three rounds: grants go 0, 1, 0. Each port's B arrives only at that port.
- Port 1 sends W two cycles before AW, and the slave delays AWREADY by 3 cycles: no M_WVALID until the grant. The transfer completes once, and the FSM enters W_RESP only after both handshakes.
- Concurrent write from port 0 to 0x04 and read from port 1 at 0x08 (slave returns 0x12345678): both complete independently. S1_RDATA = 0x12345678 and S0_RVALID stays 0.
- Slave returns BRESP = 2 and the master holds BREADY low for 4 cycles: BVALID and BRESP = 2 are held at the granted port, and the FSM stays in W_RESP until the handshake.
- ARESET pulse while in R_RESP: all outputs go to 0 within the same cycle (asynchronously). The next read request after release is granted to port 0 on a tie.
